// File: rtl/hamming_serial_decoder_if.sv
// hamming_serial_decoder_if
//   Bus bundle for the serial Hamming decoder.
//   Receive side (master -> slave): in_valid, in_bit, in_sof, cnt_clr.
//   Result side (slave -> master): out_valid, out_code[N-1:0], out_data[K-1:0],
//   out_syndrome[M-1:0], err_corr, err_uncorr, frame_err,
//   corr_count[CNT_W-1:0], uncorr_count[CNT_W-1:0].
//
// Handshake: in_valid qualifies in_bit/in_sof on a rising edge. There is no
// ready; the decoder accepts one bit per cycle without backpressure. in_sof
// means nothing while in_valid is low. out_valid is a one-cycle strobe. The
// result fields hold their value until the next strobe. err_* are meaningful
// only while out_valid is high. frame_err is an independent one-cycle pulse.
interface hamming_serial_decoder_if #(
  parameter int M     = 3,
  parameter int CNT_W = 16
);
  localparam int N = (1 << M) - 1;
  localparam int K = N - M;

  logic             in_valid;
  logic             in_bit;
  logic             in_sof;
  logic             cnt_clr;
  logic             out_valid;
  logic [N-1:0]     out_code;
  logic [K-1:0]     out_data;
  logic [M-1:0]     out_syndrome;
  logic             err_corr;
  logic             err_uncorr;
  logic             frame_err;
  logic [CNT_W-1:0] corr_count;
  logic [CNT_W-1:0] uncorr_count;

  modport master (
    output in_valid, in_bit, in_sof, cnt_clr,
    input  out_valid, out_code, out_data, out_syndrome,
    input  err_corr, err_uncorr, frame_err, corr_count, uncorr_count
  );

  modport slave (
    input  in_valid, in_bit, in_sof, cnt_clr,
    output out_valid, out_code, out_data, out_syndrome,
    output err_corr, err_uncorr, frame_err, corr_count, uncorr_count
  );
endinterface

// File: rtl/hamming_serial_decoder.sv
// hamming_serial_decoder
//   Serial positional Hamming decoder. Each bit is accepted one per cycle.
//   The order is positions 1..N, then the overall parity bit (position 0)
//   when EXT_PARITY=1. The syndrome and the overall parity accumulate as the
//   bits arrive. One cycle after the last bit, the decoder registers the
//   corrected codeword, the data bits, the raw syndrome and the error flags.
//   It also raises out_valid for that one cycle.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    hamming_serial_decoder_if.slave (bit input, results, counters)
module hamming_serial_decoder #(
  parameter int M          = 3,
  parameter int EXT_PARITY = 0,
  parameter int CNT_W      = 16
) (
  input logic                     clk,
  input logic                     reset,
  hamming_serial_decoder_if.slave bus
);
  localparam int N     = (1 << M) - 1;
  localparam int K     = N - M;
  localparam int L     = N + EXT_PARITY;
  localparam int POS_W = M + 1;

  localparam logic [POS_W-1:0] POS_FIRST     = POS_W'(1);
  localparam logic [POS_W-1:0] POS_LAST      = POS_W'(L);
  localparam logic [POS_W-1:0] POS_CODE_LAST = POS_W'(N);
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;

  // Frame state
  logic [POS_W-1:0] pos;
  logic [M-1:0]     syn;
  logic             par;
  logic [N-1:0]     frame;   // shift register: position 1 ends up in bit 0

  // Registered outputs
  logic             out_valid_q, err_corr_q, err_uncorr_q, frame_err_q;
  logic [N-1:0]     out_code_q;
  logic [K-1:0]     out_data_q;
  logic [M-1:0]     out_syndrome_q;
  logic [CNT_W-1:0] corr_cnt_q, uncorr_cnt_q;

  // Next-state / decode values for the bit on the bus this cycle
  logic             abort, last, flip, corr, uncorr, par_nx;
  logic [POS_W-1:0] cur_pos;
  logic [M-1:0]     syn_nx;
  logic [N-1:0]     frame_nx, code_fix;
  logic [K-1:0]     data_fix;

  // Data bits are the non-power-of-two positions, in ascending order.
  function automatic logic [K-1:0] extract(input logic [N-1:0] c);
    logic [K-1:0] d;
    int           k;
    d = '0;
    k = 0;
    for (int j = 1; j <= N; j++) begin
      if ((j & (j - 1)) != 0) begin
        d[k] = c[j-1];
        k++;
      end
    end
    return d;
  endfunction

  always_comb begin
    // An in_sof in the middle of a frame restarts at position 1. The
    // accumulators for that bit start from zero.
    abort    = bus.in_sof && (pos != POS_FIRST);
    cur_pos  = abort ? POS_FIRST : pos;
    // The parity slot is position 2^M. Its low M bits are zero, so it does
    // not change the syndrome.
    syn_nx   = (abort ? '0 : syn) ^ (bus.in_bit ? cur_pos[M-1:0] : '0);
    par_nx   = (abort ? 1'b0 : par) ^ bus.in_bit;
    frame_nx = frame;
    if (cur_pos <= POS_CODE_LAST) frame_nx = {bus.in_bit, frame[N-1:1]};
    last     = (cur_pos == POS_LAST);

    if (EXT_PARITY != 0) begin
      flip   = (syn_nx != '0) && par_nx;
      corr   = par_nx;                      // single error: code bit or p0 itself
      uncorr = (syn_nx != '0) && !par_nx;
    end else begin
      flip   = (syn_nx != '0);
      corr   = flip;
      uncorr = 1'b0;
    end

    code_fix = frame_nx;
    for (int j = 0; j < N; j++) begin
      if (flip && (syn_nx == M'(j + 1))) code_fix[j] = ~frame_nx[j];
    end
    data_fix = extract(code_fix);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos            <= POS_FIRST;
      syn            <= '0;
      par            <= 1'b0;
      frame          <= '0;
      out_valid_q    <= 1'b0;
      out_code_q     <= '0;
      out_data_q     <= '0;
      out_syndrome_q <= '0;
      err_corr_q     <= 1'b0;
      err_uncorr_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      corr_cnt_q     <= '0;
      uncorr_cnt_q   <= '0;
    end else begin
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (bus.in_valid) begin
        frame_err_q <= abort;
        frame       <= frame_nx;
        if (last) begin
          pos            <= POS_FIRST;
          syn            <= '0;
          par            <= 1'b0;
          out_valid_q    <= 1'b1;
          out_code_q     <= code_fix;
          out_data_q     <= data_fix;
          out_syndrome_q <= syn_nx;
          err_corr_q     <= corr;
          err_uncorr_q   <= uncorr;
        end else begin
          pos <= cur_pos + 1'b1;
          syn <= syn_nx;
          par <= par_nx;
        end
      end

      // A clear wins over a same-edge increment.
      if (bus.cnt_clr) corr_cnt_q <= '0;
      else if (bus.in_valid && last && corr && (corr_cnt_q != CNT_MAX))
        corr_cnt_q <= corr_cnt_q + 1'b1;

      if (bus.cnt_clr) uncorr_cnt_q <= '0;
      else if (bus.in_valid && last && uncorr && (uncorr_cnt_q != CNT_MAX))
        uncorr_cnt_q <= uncorr_cnt_q + 1'b1;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_code     = out_code_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_syndrome = out_syndrome_q;
  assign bus.err_corr     = err_corr_q;
  assign bus.err_uncorr   = err_uncorr_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.corr_count   = corr_cnt_q;
  assign bus.uncorr_count = uncorr_cnt_q;
endmodule

// File: tb/tb_hamming_serial_decoder.sv
// tb_hamming_serial_decoder
//   Bench for hamming_serial_decoder. It uses four instances:
//     d0: M=3, no extended parity, 16-bit counters
//     d1: M=3, extended parity, 16-bit counters
//     d2: M=3, no extended parity, 2-bit counters (saturation)
//     d3: M=4, extended parity, 8-bit counters
//   Expected results come from an encoder and a decoder model. The model
//   works on plain position arithmetic.
module tb_hamming_serial_decoder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hamming_serial_decoder_if #(.M(3), .CNT_W(16)) ifc0 ();
  hamming_serial_decoder_if #(.M(3), .CNT_W(16)) ifc1 ();
  hamming_serial_decoder_if #(.M(3), .CNT_W(2))  ifc2 ();
  hamming_serial_decoder_if #(.M(4), .CNT_W(8))  ifc3 ();

  hamming_serial_decoder #(.M(3), .EXT_PARITY(0), .CNT_W(16)) dut0 (.clk(clk), .reset(reset), .bus(ifc0));
  hamming_serial_decoder #(.M(3), .EXT_PARITY(1), .CNT_W(16)) dut1 (.clk(clk), .reset(reset), .bus(ifc1));
  hamming_serial_decoder #(.M(3), .EXT_PARITY(0), .CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(ifc2));
  hamming_serial_decoder #(.M(4), .EXT_PARITY(1), .CNT_W(8))  dut3 (.clk(clk), .reset(reset), .bus(ifc3));

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- driver ----------------
  task automatic set_in(input int d, input bit v, input bit b, input bit s, input bit c);
    case (d)
      0: begin ifc0.in_valid = v; ifc0.in_bit = b; ifc0.in_sof = s; ifc0.cnt_clr = c; end
      1: begin ifc1.in_valid = v; ifc1.in_bit = b; ifc1.in_sof = s; ifc1.cnt_clr = c; end
      2: begin ifc2.in_valid = v; ifc2.in_bit = b; ifc2.in_sof = s; ifc2.cnt_clr = c; end
      default: begin ifc3.in_valid = v; ifc3.in_bit = b; ifc3.in_sof = s; ifc3.cnt_clr = c; end
    endcase
  endtask

  // Present inputs for one edge; outputs are stable on return (#1 after edge).
  task automatic drive(input int d, input bit v, input bit b, input bit s, input bit c);
    set_in(d, v, b, s, c);
    @(posedge clk);
    #1;
    set_in(d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic bit ov(input int d);
    case (d)
      0: return ifc0.out_valid;
      1: return ifc1.out_valid;
      2: return ifc2.out_valid;
      default: return ifc3.out_valid;
    endcase
  endfunction

  task automatic get_out(input int d, output logic [63:0] code, output logic [63:0] data,
                         output int syn, output bit v, output bit corr, output bit uncorr,
                         output bit ferr, output int cc, output int uc);
    case (d)
      0: begin code = 64'(ifc0.out_code); data = 64'(ifc0.out_data); syn = int'(ifc0.out_syndrome);
               v = ifc0.out_valid; corr = ifc0.err_corr; uncorr = ifc0.err_uncorr; ferr = ifc0.frame_err;
               cc = int'(ifc0.corr_count); uc = int'(ifc0.uncorr_count); end
      1: begin code = 64'(ifc1.out_code); data = 64'(ifc1.out_data); syn = int'(ifc1.out_syndrome);
               v = ifc1.out_valid; corr = ifc1.err_corr; uncorr = ifc1.err_uncorr; ferr = ifc1.frame_err;
               cc = int'(ifc1.corr_count); uc = int'(ifc1.uncorr_count); end
      2: begin code = 64'(ifc2.out_code); data = 64'(ifc2.out_data); syn = int'(ifc2.out_syndrome);
               v = ifc2.out_valid; corr = ifc2.err_corr; uncorr = ifc2.err_uncorr; ferr = ifc2.frame_err;
               cc = int'(ifc2.corr_count); uc = int'(ifc2.uncorr_count); end
      default: begin code = 64'(ifc3.out_code); data = 64'(ifc3.out_data); syn = int'(ifc3.out_syndrome);
               v = ifc3.out_valid; corr = ifc3.err_corr; uncorr = ifc3.err_uncorr; ferr = ifc3.frame_err;
               cc = int'(ifc3.corr_count); uc = int'(ifc3.uncorr_count); end
    endcase
  endtask

  // Send one frame (positions 1..N then p0 if ext). Count out_valid seen
  // before the last bit. The out_valid check runs after every non-final bit
  // and after every gap cycle.
  task automatic send_frame(input int d, input int m, input bit ext, input logic [63:0] raw,
                            input bit p0, input bit sof1, input bit gaps, input bit clr_last,
                            output int early);
    int n, len;
    bit b;
    n = (1 << m) - 1;
    len = n + int'(ext);
    early = 0;
    for (int i = 1; i <= len; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          drive(d, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
          if (ov(d)) early++;
        end
      end
      b = (i <= n) ? raw[i-1] : p0;
      drive(d, 1'b1, b, sof1 && (i == 1), clr_last && (i == len));
      if (i < len && ov(d)) early++;
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] encode(input int m, input logic [63:0] dw);
    int n = (1 << m) - 1;
    int k = 0;
    int s = 0;
    logic [63:0] c = '0;
    for (int j = 1; j <= n; j++) begin
      if ((j & (j - 1)) != 0) begin
        c[j-1] = dw[k];
        k++;
        if (dw[k-1]) s ^= j;
      end
    end
    for (int i = 0; i < m; i++) c[(1 << i) - 1] = s[i];
    return c;
  endfunction

  function automatic void model(input int m, input bit ext, input logic [63:0] raw, input bit p0,
                                output logic [63:0] code, output logic [63:0] data,
                                output int syn, output bit corr, output bit uncorr);
    int n = (1 << m) - 1;
    int ones = int'(p0);
    int k = 0;
    syn = 0;
    for (int j = 1; j <= n; j++) begin
      if (raw[j-1]) begin
        syn ^= j;
        ones++;
      end
    end
    code = raw;
    corr = 1'b0;
    uncorr = 1'b0;
    if (!ext) begin
      if (syn != 0) begin code[syn-1] = ~code[syn-1]; corr = 1'b1; end
    end else if (ones % 2 == 1) begin
      corr = 1'b1;
      if (syn != 0) code[syn-1] = ~code[syn-1];
    end else if (syn != 0) begin
      uncorr = 1'b1;
    end
    data = '0;
    for (int j = 1; j <= n; j++) begin
      if ((j & (j - 1)) != 0) begin data[k] = code[j-1]; k++; end
    end
  endfunction

  // ---------------- scenario tasks ----------------
  logic [63:0] o_code, o_data;
  int o_syn, o_cc, o_uc, early;
  bit o_v, o_corr, o_unc, o_ferr;

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < 4; d++) set_in(d, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      get_out(d, o_code, o_data, o_syn, o_v, o_corr, o_unc, o_ferr, o_cc, o_uc);
      tests_run++; if ({o_v, o_corr, o_unc, o_ferr} !== 4'b0) begin tests_failed++; $display("FAIL reset_flags d%0d: got %b exp 0000", d, {o_v, o_corr, o_unc, o_ferr}); end
      tests_run++; if ({o_code, o_data} !== 128'b0 || o_syn != 0) begin tests_failed++; $display("FAIL reset_data d%0d: code %h data %h syn %0d exp 0", d, o_code, o_data, o_syn); end
      tests_run++; if (o_cc != 0 || o_uc != 0) begin tests_failed++; $display("FAIL reset_counts d%0d: corr %0d uncorr %0d exp 0 0", d, o_cc, o_uc); end
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_clean();
    send_frame(0, 3, 1'b0, 64'h55, 1'b0, 1'b1, 1'b0, 1'b0, early);
    get_out(0, o_code, o_data, o_syn, o_v, o_corr, o_unc, o_ferr, o_cc, o_uc);
    tests_run++; if (o_v !== 1'b1 || early != 0) begin tests_failed++; $display("FAIL clean_valid: got %b early %0d exp 1 0", o_v, early); end
    tests_run++; if (o_code !== 64'h55 || o_data !== 64'hb) begin tests_failed++; $display("FAIL clean_data: code %h data %h exp 55 b", o_code, o_data); end
    tests_run++; if (o_syn != 0 || o_corr !== 1'b0) begin tests_failed++; $display("FAIL clean_status: syn %0d corr %b exp 0 0", o_syn, o_corr); end
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++; if (ov(0) !== 1'b0) begin tests_failed++; $display("FAIL clean_strobe: out_valid %b exp 0", ov(0)); end
  endtask

  task automatic test_single_error();
    send_frame(0, 3, 1'b0, 64'h75, 1'b0, 1'b1, 1'b0, 1'b0, early);
    get_out(0, o_code, o_data, o_syn, o_v, o_corr, o_unc, o_ferr, o_cc, o_uc);
    tests_run++; if (o_v !== 1'b1 || o_syn != 6 || o_corr !== 1'b1) begin tests_failed++; $display("FAIL sec_status: v %b syn %0d corr %b exp 1 6 1", o_v, o_syn, o_corr); end
    tests_run++; if (o_code !== 64'h55 || o_data !== 64'hb) begin tests_failed++; $display("FAIL sec_data: code %h data %h exp 55 b", o_code, o_data); end
    tests_run++; if (o_cc != 1) begin tests_failed++; $display("FAIL sec_count: got %0d exp 1", o_cc); end
  endtask

  task automatic test_double_error();
    send_frame(1, 3, 1'b1, 64'h47, 1'b0, 1'b1, 1'b0, 1'b0, early);
    get_out(1, o_code, o_data, o_syn, o_v, o_corr, o_unc, o_ferr, o_cc, o_uc);
    tests_run++; if (o_v !== 1'b1 || o_syn != 7) begin tests_failed++; $display("FAIL ded_syn: v %b syn %0d exp 1 7", o_v, o_syn); end
    tests_run++; if (o_unc !== 1'b1 || o_corr !== 1'b0) begin tests_failed++; $display("FAIL ded_flags: uncorr %b corr %b exp 1 0", o_unc, o_corr); end
    tests_run++; if (o_code !== 64'h47 || o_uc != 1) begin tests_failed++; $display("FAIL ded_raw: code %h uncorr_count %0d exp 47 1", o_code, o_uc); end
  endtask

  task automatic test_ext_parity_err();
    send_frame(1, 3, 1'b1, 64'h55, 1'b1, 1'b1, 1'b0, 1'b0, early);
    get_out(1, o_code, o_data, o_syn, o_v, o_corr, o_unc, o_ferr, o_cc, o_uc);
    tests_run++; if (o_v !== 1'b1 || o_syn != 0 || o_corr !== 1'b1 || o_unc !== 1'b0) begin tests_failed++; $display("FAIL p0_status: v %b syn %0d corr %b uncorr %b exp 1 0 1 0", o_v, o_syn, o_corr, o_unc); end
    tests_run++; if (o_data !== 64'hb || o_code !== 64'h55) begin tests_failed++; $display("FAIL p0_data: code %h data %h exp 55 b", o_code, o_data); end
  endtask

  task automatic test_frame_abort();
    logic [63:0] raw;
    int bad_v;
    raw = 64'h75;
    bad_v = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 1'b1, i == 0, 1'b0);
      if (ov(0)) bad_v++;
    end
    drive(0, 1'b1, raw[0], 1'b1, 1'b0);
    get_out(0, o_code, o_data, o_syn, o_v, o_corr, o_unc, o_ferr, o_cc, o_uc);
    tests_run++; if (o_ferr !== 1'b1 || o_v !== 1'b0 || bad_v != 0) begin tests_failed++; $display("FAIL abort_pulse: frame_err %b out_valid %b early %0d exp 1 0 0", o_ferr, o_v, bad_v); end
    for (int i = 2; i <= 7; i++) begin
      drive(0, 1'b1, raw[i-1], 1'b0, 1'b0);
      if (i == 2) begin
        tests_run++; if (ifc0.frame_err !== 1'b0) begin tests_failed++; $display("FAIL abort_width: frame_err %b exp 0", ifc0.frame_err); end
      end
      if (i < 7 && ov(0)) bad_v++;
    end
    get_out(0, o_code, o_data, o_syn, o_v, o_corr, o_unc, o_ferr, o_cc, o_uc);
    tests_run++; if (o_v !== 1'b1 || bad_v != 0 || o_code !== 64'h55 || o_syn != 6) begin tests_failed++; $display("FAIL abort_decode: v %b early %0d code %h syn %0d exp 1 0 55 6", o_v, bad_v, o_code, o_syn); end
    tests_run++; if (o_cc != 2) begin tests_failed++; $display("FAIL abort_count: got %0d exp 2", o_cc); end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 3; i++) drive(0, 1'b1, 1'b1, i == 0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    get_out(0, o_code, o_data, o_syn, o_v, o_corr, o_unc, o_ferr, o_cc, o_uc);
    tests_run++; if (o_v !== 1'b0 || o_cc != 0 || o_code !== 64'h0) begin tests_failed++; $display("FAIL rst_mid: v %b count %0d code %h exp 0 0 0", o_v, o_cc, o_code); end
    // No in_sof: decodes correctly only if framing restarted at position 1
    send_frame(0, 3, 1'b0, 64'h5d, 1'b0, 1'b0, 1'b0, 1'b0, early);
    get_out(0, o_code, o_data, o_syn, o_v, o_corr, o_unc, o_ferr, o_cc, o_uc);
    tests_run++; if (o_v !== 1'b1 || o_code !== 64'h55 || o_syn != 4 || o_ferr !== 1'b0) begin tests_failed++; $display("FAIL rst_resume: v %b code %h syn %0d ferr %b exp 1 55 4 0", o_v, o_code, o_syn, o_ferr); end
  endtask

  task automatic test_back_to_back();
    int exp_cnt[6] = '{1, 2, 3, 3, 0, 1};
    for (int f = 0; f < 6; f++) begin
      send_frame(2, 3, 1'b0, 64'h75, 1'b0, 1'b1, 1'b0, f == 4, early);
      get_out(2, o_code, o_data, o_syn, o_v, o_corr, o_unc, o_ferr, o_cc, o_uc);
      tests_run++; if (o_v !== 1'b1 || early != 0 || o_corr !== 1'b1 || o_code !== 64'h55) begin tests_failed++; $display("FAIL b2b_frame%0d: v %b early %0d corr %b code %h exp 1 0 1 55", f, o_v, early, o_corr, o_code); end
      tests_run++; if (o_cc != exp_cnt[f]) begin tests_failed++; $display("FAIL b2b_count%0d: got %0d exp %0d", f, o_cc, exp_cnt[f]); end
    end
  endtask

  task automatic test_random();
    int dl[3] = '{0, 1, 3};
    int ml[3] = '{3, 3, 4};
    bit el[3] = '{1'b0, 1'b1, 1'b1};
    int d, m, n, len, nerr, e1, e2, ecc, euc, e_syn;
    bit ext, p0, e_corr, e_unc;
    logic [63:0] raw, e_code, e_data;
    for (int t = 0; t < 3; t++) begin
      d = dl[t]; m = ml[t]; ext = el[t];
      n = (1 << m) - 1;
      len = n + int'(ext);
      ecc = 0; euc = 0;
      drive(d, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int f = 0; f < 30; f++) begin
        raw = encode(m, {$urandom, $urandom});
        p0 = ^raw;
        nerr = $urandom_range(0, 2);
        e1 = $urandom_range(0, len - 1);
        e2 = (e1 + 1 + $urandom_range(0, len - 2)) % len;
        if (nerr >= 1) begin if (e1 < n) raw[e1] = ~raw[e1]; else p0 = ~p0; end
        if (nerr == 2) begin if (e2 < n) raw[e2] = ~raw[e2]; else p0 = ~p0; end
        model(m, ext, raw, p0, e_code, e_data, e_syn, e_corr, e_unc);
        if (e_corr) ecc++;
        if (e_unc) euc++;
        send_frame(d, m, ext, raw, p0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, early);
        get_out(d, o_code, o_data, o_syn, o_v, o_corr, o_unc, o_ferr, o_cc, o_uc);
        tests_run++; if (o_v !== 1'b1 || early != 0) begin tests_failed++; $display("FAIL rnd_valid d%0d f%0d: v %b early %0d exp 1 0", d, f, o_v, early); end
        tests_run++; if (o_code !== e_code || o_data !== e_data) begin tests_failed++; $display("FAIL rnd_data d%0d f%0d: code %h data %h exp %h %h", d, f, o_code, o_data, e_code, e_data); end
        tests_run++; if (o_syn != e_syn || o_corr !== e_corr || o_unc !== e_unc) begin tests_failed++; $display("FAIL rnd_status d%0d f%0d: syn %0d corr %b uncorr %b exp %0d %b %b", d, f, o_syn, o_corr, o_unc, e_syn, e_corr, e_unc); end
      end
      tests_run++; if (o_cc != ecc || o_uc != euc) begin tests_failed++; $display("FAIL rnd_counts d%0d: corr %0d uncorr %0d exp %0d %0d", d, o_cc, o_uc, ecc, euc); end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_double_error();
    test_ext_parity_err();
    test_frame_abort();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
